ram_arb2: RTL and testbench



---
 rtl/ram_arb_pkg.sv | 18 +
 rtl/ram_arb2_if.sv | 27 ++
 rtl/rr_arb2.sv | 36 +++
 rtl/ram_arb2.sv | 139 +++++++++++++
 tb/tb_ram_arb2.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter: FSM state, master index,
// master count and a small index-to-grant helper.
package ram_arb_pkg;

   localparam int NUM_MASTERS = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef logic midx_t;

   function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(midx_t idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/ram_arb2_if.sv
// Valid/ready request + response bundle between a requester and a RAM-like
// responder. 'master' is the requesting side, 'slave' the responding side.
interface ram_arb2_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   addr;
   logic [DW-1:0]   wdata;
   logic [DW/8-1:0] sel;
   logic            we;
   logic            req_valid;
   logic            req_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [DW-1:0]   rdata;

   modport master (
      output addr, wdata, sel, we, req_valid, rsp_ready,
      input  req_ready, rsp_valid, rdata
   );

   modport slave (
      input  addr, wdata, sel, we, req_valid, rsp_ready,
      output req_ready, rsp_valid, rdata
   );

endinterface

// File: rtl/rr_arb2.sv
// Pure two-way grant logic. A held grant always wins; otherwise a lone
// request is granted, and a tie goes to the master that was not served last.
// With RAM_ARB_FIXED_PRIO_EN defined a tie always goes to master 0 and the
// 'last' input is ignored.
module rr_arb2
   import ram_arb_pkg::*;
(
   input  logic [NUM_MASTERS-1:0] req,
   input  midx_t                  last,
   input  logic                   hold,
   input  midx_t                  held,
   output logic [NUM_MASTERS-1:0] gnt
);

   // Grant selection: hold, then tie-break, then single requester.
   always_comb begin
      gnt = '0;
      if (hold) begin
         gnt = idx_to_onehot(held) & req;
      end else if (req == 2'b11) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
         gnt = 2'b01;
`else
         gnt = idx_to_onehot(~last);
`endif
      end else begin
         gnt = req;
      end
   end

`ifdef RAM_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = last;
`endif

endmodule

// File: rtl/ram_arb2.sv
// Two-master arbiter in front of the data RAM (m0 = core LSU, m1 = debug/DMA).
// Forwards one request at a time with zero added latency, tracks the single
// outstanding transaction and steers the RAM response back to its owner.
// Round-robin by default; RAM_ARB_FIXED_PRIO_EN selects fixed priority (m0).
module ram_arb2
   import ram_arb_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input logic         clk,
   input logic         rst,
   ram_arb2_if.slave   m0,
   ram_arb2_if.slave   m1,
   ram_arb2_if.master  s
);

   state_t                 state_q;
   midx_t                  owner_q;
   logic                   hold_q;
   midx_t                  hold_idx_q;
   midx_t                  last_sig;
`ifndef RAM_ARB_FIXED_PRIO_EN
   midx_t                  rr_last_q;
`endif

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] gnt;
   midx_t                  gnt_idx;
   logic                   own_rsp_ready;
   logic                   rsp_hs;
   logic                   can_issue;
   logic                   s_req_vld;
   logic                   s_acc;

   logic [AW-1:0]          mux_addr;
   logic [DW-1:0]          mux_wdata;
   logic [DW/8-1:0]        mux_sel;
   logic                   mux_we;

`ifdef RAM_ARB_FIXED_PRIO_EN
   assign last_sig = 1'b1;
`else
   assign last_sig = rr_last_q;
`endif

   // Response ready of whichever master owns the outstanding transaction.
   always_comb begin
      own_rsp_ready = m0.rsp_ready;
      if (owner_q == 1'b1) own_rsp_ready = m1.rsp_ready;
   end

   // A new request may only be presented when nothing is outstanding or the
   // outstanding response completes this very cycle (back-to-back issue).
   assign rsp_hs    = !rst && (state_q == BUSY) && s.rsp_valid && own_rsp_ready;
   assign can_issue = !rst && ((state_q == IDLE) || rsp_hs);
   assign req       = {m1.req_valid, m0.req_valid} & {NUM_MASTERS{can_issue}};

   rr_arb2 u_arb (
      .req  (req),
      .last (last_sig),
      .hold (hold_q),
      .held (hold_idx_q),
      .gnt  (gnt)
   );

   assign gnt_idx   = gnt[1];
   assign s_req_vld = |gnt;
   assign s_acc     = s_req_vld && s.req_ready;

   // Request field mux: granted master's fields go straight to the RAM.
   always_comb begin
      mux_addr  = m0.addr;
      mux_wdata = m0.wdata;
      mux_sel   = m0.sel;
      mux_we    = m0.we;
      if (gnt_idx == 1'b1) begin
         mux_addr  = m1.addr;
         mux_wdata = m1.wdata;
         mux_sel   = m1.sel;
         mux_we    = m1.we;
      end
   end

   assign s.addr      = mux_addr;
   assign s.wdata     = mux_wdata;
   assign s.sel       = mux_sel;
   assign s.we        = mux_we;
   assign s.req_valid = s_req_vld;

   // Accept is a combinational pass-through of the RAM ready to the granted master.
   assign m0.req_ready = gnt[0] && s.req_ready;
   assign m1.req_ready = gnt[1] && s.req_ready;

   // Response steering: only the owner ever sees rsp_valid; RAM responses
   // arriving while idle are refused.
   assign s.rsp_ready  = !rst && (state_q == BUSY) && own_rsp_ready;
   assign m0.rsp_valid = !rst && (state_q == BUSY) && s.rsp_valid && (owner_q == 1'b0);
   assign m1.rsp_valid = !rst && (state_q == BUSY) && s.rsp_valid && (owner_q == 1'b1);
   assign m0.rdata     = s.rdata;
   assign m1.rdata     = s.rdata;

   // Transaction tracking: state, owner, grant lock and round-robin history.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         owner_q    <= 1'b0;
         hold_q     <= 1'b0;
         hold_idx_q <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIO_EN
         rr_last_q  <= 1'b1;
`endif
      end else begin
         hold_q     <= s_req_vld && !s.req_ready;
         hold_idx_q <= gnt_idx;
         if (s_acc) begin
            state_q <= BUSY;
            owner_q <= gnt_idx;
`ifndef RAM_ARB_FIXED_PRIO_EN
            rr_last_q <= gnt_idx;
`endif
         end else if (rsp_hs) begin
            state_q <= IDLE;
         end
      end
   end

   // A RAM response with nothing outstanding indicates a broken slave.
   a_no_rsp_idle: assert property (@(posedge clk) disable iff (rst)
      !((state_q == IDLE) && s.rsp_valid));

   // At most one master granted at a time.
   a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

   // A master whose request is stalled must keep it valid until accepted.
   a_hold_valid: assert property (@(posedge clk) disable iff (rst)
      hold_q |-> (hold_idx_q ? m1.req_valid : m0.req_valid));

endmodule

// File: tb/tb_ram_arb2.sv
// Directed bench for ram_arb2 with a small behavioural RAM (one-cycle
// response, byte-enable writes, stallable request ready).
module tb_ram_arb2;

`ifdef RAM_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ram_arb2_if m0_if ();
   ram_arb2_if m1_if ();
   ram_arb2_if s_if ();

   ram_arb2 dut (
      .clk (clk),
      .rst (rst),
      .m0  (m0_if),
      .m1  (m1_if),
      .s   (s_if)
   );

   int n_chk = 0;
   int n_err = 0;

   logic [31:0] mem [16];
   logic        ram_rdy;
   logic        ram_rsp_vld;
   logic [31:0] ram_rdata;

   assign s_if.req_ready = ram_rdy;
   assign s_if.rsp_valid = ram_rsp_vld;
   assign s_if.rdata     = ram_rdata;

   // RAM model: answers each accepted request on the following cycle.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ram_rsp_vld <= 1'b0;
         ram_rdata   <= '0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         mem[13] <= 32'hDEAD_BEEF;
      end else begin
         if (ram_rsp_vld && s_if.rsp_ready) ram_rsp_vld <= 1'b0;
         if (s_if.req_valid && s_if.req_ready) begin
            ram_rsp_vld <= 1'b1;
            if (s_if.we) begin
               for (int b = 0; b < 4; b++)
                  if (s_if.sel[b]) mem[s_if.addr[5:2]][8*b +: 8] <= s_if.wdata[8*b +: 8];
               ram_rdata <= '0;
            end else begin
               ram_rdata <= mem[s_if.addr[5:2]];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drv_m0(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sl, input logic w);
      m0_if.req_valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.sel = sl; m0_if.we = w;
   endtask

   task automatic drv_m1(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] sl, input logic w);
      m1_if.req_valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.sel = sl; m1_if.we = w;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      logic exp0;
      logic prev0;

      rst = 1'b1;
      ram_rdy = 1'b1;
      m0_if.rsp_ready = 1'b1;
      m1_if.rsp_ready = 1'b1;
      drv_m0(1'b1, 32'h0, 32'h0, 4'h0, 1'b0);
      drv_m1(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);

      // Reset state: nothing forwarded even with both masters requesting
      @(negedge clk);
      check("rst_s_req_valid", 32'(s_if.req_valid), 32'd0);
      check("rst_m0_req_ready", 32'(m0_if.req_ready), 32'd0);
      check("rst_m1_req_ready", 32'(m1_if.req_ready), 32'd0);
      check("rst_s_rsp_ready", 32'(s_if.rsp_ready), 32'd0);
      check("rst_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      drv_m0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      drv_m1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);

      // m0 partial write, then m1 read of the same word
      step();
      drv_m0(1'b1, 32'h10, 32'hA5A5_0000, 4'b1100, 1'b1);
      @(negedge clk);
      check("w_s_req_valid", 32'(s_if.req_valid), 32'd1);
      check("w_m0_req_ready", 32'(m0_if.req_ready), 32'd1);
      check("w_m1_req_ready", 32'(m1_if.req_ready), 32'd0);
      check("w_s_addr", s_if.addr, 32'h10);
      check("w_s_wdata", s_if.wdata, 32'hA5A5_0000);
      check("w_s_sel", 32'(s_if.sel), 32'hC);
      check("w_s_we", 32'(s_if.we), 32'd1);
      step();
      drv_m0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      check("w_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'd1);
      check("w_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd0);
      check("w_s_rsp_ready", 32'(s_if.rsp_ready), 32'd1);
      step();
      drv_m1(1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
      @(negedge clk);
      check("r_m1_req_ready", 32'(m1_if.req_ready), 32'd1);
      check("r_m0_req_ready", 32'(m0_if.req_ready), 32'd0);
      check("r_s_we", 32'(s_if.we), 32'd0);
      step();
      drv_m1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      check("r_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd1);
      check("r_m1_data", m1_if.rdata, 32'hA5A5_0000);
      check("r_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'd0);
      step();
      @(negedge clk);
      check("r_idle_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd0);
      check("r_idle_s_req_valid", 32'(s_if.req_valid), 32'd0);

      // Both masters request every cycle, RAM always ready
      step();
      drv_m0(1'b1, 32'h20, 32'h0, 4'hF, 1'b0);
      drv_m1(1'b1, 32'h24, 32'h0, 4'hF, 1'b0);
      prev0 = 1'b0;
      exp0  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         exp0 = FIXED ? 1'b1 : ((k % 2) == 0);
         @(negedge clk);
         check($sformatf("rr%0d_m0_req_ready", k), 32'(m0_if.req_ready), 32'(exp0));
         check($sformatf("rr%0d_m1_req_ready", k), 32'(m1_if.req_ready), 32'(!exp0));
         check($sformatf("rr%0d_s_req_valid", k), 32'(s_if.req_valid), 32'd1);
         if (k > 0) begin
            check($sformatf("rr%0d_m0_rsp_valid", k), 32'(m0_if.rsp_valid), 32'(prev0));
            check($sformatf("rr%0d_m1_rsp_valid", k), 32'(m1_if.rsp_valid), 32'(!prev0));
         end
         prev0 = exp0;
         step();
      end
      drv_m0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      drv_m1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      check("rr_tail_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'(prev0));
      check("rr_tail_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'(!prev0));
      step();

      // m0 read so that m0 becomes the most recently served master
      drv_m0(1'b1, 32'h10, 32'h0, 4'hF, 1'b0);
      @(negedge clk);
      check("q_m0_req_ready", 32'(m0_if.req_ready), 32'd1);
      step();
      drv_m0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      check("q_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'd1);
      check("q_m0_data", m0_if.rdata, 32'hA5A5_0000);
      step();

      // RAM stalls with m0 granted; m1 arrives and must not steal the grant
      ram_rdy = 1'b0;
      drv_m0(1'b1, 32'h30, 32'h0, 4'hF, 1'b0);
      @(negedge clk);
      check("h_s_req_valid", 32'(s_if.req_valid), 32'd1);
      check("h_m0_req_ready", 32'(m0_if.req_ready), 32'd0);
      check("h_s_addr", s_if.addr, 32'h30);
      step();
      drv_m1(1'b1, 32'h34, 32'h0, 4'hF, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("h%0d_s_addr", k), s_if.addr, 32'h30);
         check($sformatf("h%0d_s_req_valid", k), 32'(s_if.req_valid), 32'd1);
         check($sformatf("h%0d_m1_req_ready", k), 32'(m1_if.req_ready), 32'd0);
         step();
      end
      ram_rdy = 1'b1;
      @(negedge clk);
      check("h_acc_m0_req_ready", 32'(m0_if.req_ready), 32'd1);
      check("h_acc_m1_req_ready", 32'(m1_if.req_ready), 32'd0);
      step();
      drv_m0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      check("b2b_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'd1);
      check("b2b_m1_req_ready", 32'(m1_if.req_ready), 32'd1);
      check("b2b_s_addr", s_if.addr, 32'h34);
      step();

      // m1 back-pressures its response; nothing new may be issued meanwhile
      drv_m1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      m1_if.rsp_ready = 1'b0;
      drv_m0(1'b1, 32'h30, 32'h0, 4'hF, 1'b0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check($sformatf("bp%0d_m1_rsp_valid", k), 32'(m1_if.rsp_valid), 32'd1);
         check($sformatf("bp%0d_s_rsp_ready", k), 32'(s_if.rsp_ready), 32'd0);
         check($sformatf("bp%0d_s_req_valid", k), 32'(s_if.req_valid), 32'd0);
         check($sformatf("bp%0d_m0_req_ready", k), 32'(m0_if.req_ready), 32'd0);
         check($sformatf("bp%0d_m1_data", k), m1_if.rdata, 32'hDEAD_BEEF);
         step();
      end
      m1_if.rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_done_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd1);
      check("bp_done_s_rsp_ready", 32'(s_if.rsp_ready), 32'd1);
      check("bp_done_m0_req_ready", 32'(m0_if.req_ready), 32'd1);
      step();
      drv_m0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      check("bp_next_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'd1);
      check("bp_next_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd0);
      step();

      // Reset pulse while a transaction is outstanding
      drv_m1(1'b1, 32'h34, 32'h0, 4'hF, 1'b0);
      m1_if.rsp_ready = 1'b0;
      @(negedge clk);
      check("rm_m1_req_ready", 32'(m1_if.req_ready), 32'd1);
      step();
      drv_m0(1'b1, 32'h20, 32'h0, 4'hF, 1'b0);
      @(negedge clk);
      check("rm_busy_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd1);
      check("rm_busy_s_req_valid", 32'(s_if.req_valid), 32'd0);
      #1;
      rst = 1'b1;
      #1;
      check("rm_rst_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd0);
      check("rm_rst_s_req_valid", 32'(s_if.req_valid), 32'd0);
      check("rm_rst_m0_req_ready", 32'(m0_if.req_ready), 32'd0);
      check("rm_rst_m1_req_ready", 32'(m1_if.req_ready), 32'd0);
      check("rm_rst_s_rsp_ready", 32'(s_if.rsp_ready), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      m1_if.rsp_ready = 1'b1;
      @(negedge clk);
      check("rm_next_m0_req_ready", 32'(m0_if.req_ready), 32'd1);
      check("rm_next_m1_req_ready", 32'(m1_if.req_ready), 32'd0);
      check("rm_next_s_addr", s_if.addr, 32'h20);
      step();
      drv_m0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      drv_m1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      check("rm_fin_m0_rsp_valid", 32'(m0_if.rsp_valid), 32'd1);
      check("rm_fin_m1_rsp_valid", 32'(m1_if.rsp_valid), 32'd0);
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
